// File: rtl/debounce_event_arbiter.sv
// Multi-channel input debouncer sharing one sample-tick prescaler; debounced level
// changes are queued per channel and serialised round-robin onto one valid/ready stream.
module debounce_event_arbiter #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 250,
  parameter int STABLE_TICKS = 1000,
  localparam int CH_W        = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_rise,
  output logic [N_CH-1:0] ovf,
  input  logic            clr_ovf
);

  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  flip;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  dir;
  logic [N_CH-1:0]  granted;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  idx;
  logic             grant_any;
  logic             load;

  assign tick = (div_cnt == DIV_LAST);
  assign load = !evt_valid || evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= in;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      flip[i] = (s[i] != level[i]) && tick && (cnt[i] == CNT_LAST);
  end

  // Walk downward so the candidate closest to ptr is the last one written.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      idx = CH_W'((int'(ptr) + off) % N_CH);
      if (pend[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    for (int i = 0; i < N_CH; i++)
      granted[i] = load && grant_any && (grant_idx == CH_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      pend  <= '0;
      dir   <= '0;
      ovf   <= '0;
      for (int i = 0; i < N_CH; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (flip[i]) begin
            level[i] <= s[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
        // A flip landing on the grant cycle re-queues with the new direction.
        if (flip[i]) begin
          pend[i] <= 1'b1;
          dir[i]  <= s[i];
        end else if (granted[i]) begin
          pend[i] <= 1'b0;
        end
        if (flip[i] && pend[i] && !granted[i])
          ovf[i] <= 1'b1;
        else if (clr_ovf)
          ovf[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (grant_any) begin
        evt_valid <= 1'b1;
        evt_ch    <= grant_idx;
        evt_rise  <= dir[grant_idx];
        ptr       <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
